// File: rtl/frame_coprocessor_pkg.sv
// Shared types and constants for the frame test-stream source.
package frame_coprocessor_pkg;

    typedef enum logic [1:0] {
        PAT_INCR   = 2'd0,
        PAT_CONST  = 2'd1,
        PAT_LFSR   = 2'd2,
        PAT_TAGGED = 2'd3
    } pattern_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    // One step of the shift-right Galois LFSR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/frame_pattern_unit.sv
// Pattern generator: holds the running pattern state and presents the current word.
module frame_pattern_unit
    import frame_coprocessor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  advance,
    input  logic [LEN_WIDTH-1:0]  frame_index,
    input  logic [LEN_WIDTH-1:0]  word_index,
    output logic [DATA_WIDTH-1:0] word
);

    pattern_mode_t         mode_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [31:0]           lfsr_q;
    logic [31:0]           seed32;
    logic [15:0]           tag_frame;
    logic [15:0]           tag_word;

    assign seed32    = 32'(seed);
    assign tag_frame = 16'(frame_index);
    assign tag_word  = 16'(word_index);

    // Pattern state: loaded at run start, stepped once per accepted beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= PAT_INCR;
            acc_q  <= '0;
            lfsr_q <= '0;
        end else if (load) begin
            mode_q <= pattern_mode_t'(mode);
            acc_q  <= seed;
            lfsr_q <= (seed32 == 32'h0) ? 32'h1 : seed32;
        end else if (advance) begin
            case (mode_q)
                PAT_INCR: acc_q  <= acc_q + 1'b1;
                PAT_LFSR: lfsr_q <= lfsr_step(lfsr_q);
                default:  ;
            endcase
        end
    end

    // Current word selected by the latched mode.
    always_comb begin
        word = '0;
        case (mode_q)
            PAT_INCR, PAT_CONST: word = acc_q;
            PAT_LFSR:            word = DATA_WIDTH'(lfsr_q);
            PAT_TAGGED:          word = DATA_WIDTH'({tag_frame, tag_word});
            default:             word = '0;
        endcase
    end

endmodule

// File: rtl/frame_stream_source.sv
// AXI-Stream master producing programmable test frames (length, count, gap, pattern).
module frame_stream_source
    import frame_coprocessor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned GAP_WIDTH  = 8
) (
    input  logic                    dataOutClock,
    input  logic                    dataOutReset,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    frameLength,
    input  logic [LEN_WIDTH-1:0]    frameCount,
    input  logic [GAP_WIDTH-1:0]    gapCycles,
    input  logic [1:0]              patternMode,
    input  logic [DATA_WIDTH-1:0]   patternSeed,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   dataOut,
    output logic                    dataOutTValid,
    input  logic                    dataOutTReady,
    output logic                    dataOutTLast,
    output logic [DATA_WIDTH/8-1:0] dataOutTStrb,
    output logic [31:0]             beatsSent
);

    state_t                state_q;
    state_t                state_d;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  count_q;
    logic [GAP_WIDTH-1:0]  gap_q;
    logic [LEN_WIDTH-1:0]  word_idx_q;
    logic [LEN_WIDTH-1:0]  frame_idx_q;
    logic [GAP_WIDTH-1:0]  gap_cnt_q;
    logic [31:0]           beats_q;
    logic [DATA_WIDTH-1:0] pattern_word;

    logic start_accept;
    logic empty_run;
    logic valid;
    logic handshake;
    logic last_word;
    logic last_frame;

    assign start_accept = start && (state_q == ST_IDLE);
    assign empty_run    = (frameLength == '0) || (frameCount == '0);
    assign valid        = (state_q == ST_SEND);
    assign handshake    = valid && dataOutTReady;
    // Compare against len-1 rather than counting to len so the index never needs an extra bit.
    assign last_word    = (word_idx_q == len_q - LEN_WIDTH'(1));
    assign last_frame   = (frame_idx_q == count_q - LEN_WIDTH'(1));

    frame_pattern_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_pattern (
        .clk         (dataOutClock),
        .reset       (dataOutReset),
        .load        (start_accept),
        .mode        (patternMode),
        .seed        (patternSeed),
        .advance     (handshake),
        .frame_index (frame_idx_q),
        .word_index  (word_idx_q),
        .word        (pattern_word)
    );

    // State register.
    always_ff @(posedge dataOutClock) begin
        if (dataOutReset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    state_d = empty_run ? ST_DONE : ST_SEND;
                end
            end
            ST_SEND: begin
                if (handshake && last_word) begin
                    if (last_frame) begin
                        state_d = ST_DONE;
                    end else if (gap_q != '0) begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_WIDTH'(1)) begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Latched config, word/frame indices, gap countdown and beat counter.
    always_ff @(posedge dataOutClock) begin
        if (dataOutReset) begin
            len_q       <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            word_idx_q  <= '0;
            frame_idx_q <= '0;
            gap_cnt_q   <= '0;
            beats_q     <= '0;
        end else begin
            if (start_accept) begin
                len_q       <= frameLength;
                count_q     <= frameCount;
                gap_q       <= gapCycles;
                word_idx_q  <= '0;
                frame_idx_q <= '0;
                beats_q     <= '0;
            end
            if (handshake) begin
                beats_q <= beats_q + 32'd1;
                if (last_word) begin
                    word_idx_q  <= '0;
                    frame_idx_q <= frame_idx_q + LEN_WIDTH'(1);
                end else begin
                    word_idx_q <= word_idx_q + LEN_WIDTH'(1);
                end
            end
            if (state_q == ST_SEND && state_d == ST_GAP) begin
                gap_cnt_q <= gap_q;
            end else if (state_q == ST_GAP) begin
                gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
            end
        end
    end

    // Stream and status outputs decoded from registered state.
    always_comb begin
        busy          = (state_q == ST_SEND) || (state_q == ST_GAP);
        done          = (state_q == ST_DONE);
        dataOutTValid = valid;
        dataOutTLast  = valid && last_word;
        dataOutTStrb  = valid ? '1 : '0;
        dataOut       = valid ? pattern_word : '0;
        beatsSent     = beats_q;
    end

endmodule

// File: tb/tb_frame_stream_source.sv
// Directed self-checking bench for frame_stream_source.
module tb_frame_stream_source;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] frame_length;
    logic [15:0] frame_count;
    logic [7:0]  gap_cycles;
    logic [1:0]  pattern_mode;
    logic [31:0] pattern_seed;
    logic        busy;
    logic        done;
    logic [31:0] data;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [3:0]  tstrb;
    logic [31:0] beats;

    int checks   = 0;
    int failures = 0;

    logic [31:0] got_words[$];
    bit          got_last[$];
    int          gap_runs[$];
    int          stall_err;
    int          strb_err;
    int          done_cyc;
    int          last_hs_cyc;
    bit          done_seen;

    frame_stream_source #(
        .DATA_WIDTH (32),
        .LEN_WIDTH  (16),
        .GAP_WIDTH  (8)
    ) dut (
        .dataOutClock  (clk),
        .dataOutReset  (rst),
        .start         (start),
        .frameLength   (frame_length),
        .frameCount    (frame_count),
        .gapCycles     (gap_cycles),
        .patternMode   (pattern_mode),
        .patternSeed   (pattern_seed),
        .busy          (busy),
        .done          (done),
        .dataOut       (data),
        .dataOutTValid (tvalid),
        .dataOutTReady (tready),
        .dataOutTLast  (tlast),
        .dataOutTStrb  (tstrb),
        .beatsSent     (beats)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Pulse start with the given config, then scramble the config inputs.
    task automatic do_start(input logic [15:0] len, input logic [15:0] cnt, input logic [7:0] gap,
                            input logic [1:0] mode, input logic [31:0] seed);
        @(negedge clk);
        tready       = 1'b0;
        frame_length = len;
        frame_count  = cnt;
        gap_cycles   = gap;
        pattern_mode = mode;
        pattern_seed = seed;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        frame_length = 16'h0005;
        frame_count  = 16'h0009;
        gap_cycles   = 8'h07;
        pattern_mode = ~mode;
        pattern_seed = 32'hA5A5_5A5A;
    endtask

    // Drive ready and record accepted beats, stall stability and gap lengths until done or timeout.
    task automatic run_stream(input int max_cycles, input bit stall_pat);
        logic [31:0] held_data;
        logic        held_last;
        bit          stalled;
        int          idle_run;
        got_words.delete();
        got_last.delete();
        gap_runs.delete();
        stalled     = 1'b0;
        held_data   = '0;
        held_last   = 1'b0;
        idle_run    = 0;
        done_seen   = 1'b0;
        done_cyc    = -1;
        last_hs_cyc = -1;
        stall_err   = 0;
        strb_err    = 0;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            tready = stall_pat ? ((cyc % 3) == 0) : 1'b1;
            #1;
            if (tstrb !== (tvalid ? 4'hF : 4'h0)) strb_err++;
            if (done === 1'b1) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                break;
            end
            if (stalled && (tvalid !== 1'b1 || data !== held_data || tlast !== held_last)) stall_err++;
            if (tvalid === 1'b1) begin
                if (idle_run > 0) begin
                    gap_runs.push_back(idle_run);
                    idle_run = 0;
                end
                if (tready) begin
                    got_words.push_back(data);
                    got_last.push_back(tlast);
                    stalled     = 1'b0;
                    last_hs_cyc = cyc;
                end else begin
                    stalled   = 1'b1;
                    held_data = data;
                    held_last = tlast;
                end
            end else if (busy === 1'b1) begin
                idle_run++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] exp_words[$];
        logic [31:0] s;
        int          bad;

        rst          = 1'b1;
        start        = 1'b0;
        tready       = 1'b0;
        frame_length = '0;
        frame_count  = '0;
        gap_cycles   = '0;
        pattern_mode = '0;
        pattern_seed = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy",   {31'b0, busy},   32'h0);
        check("reset_done",   {31'b0, done},   32'h0);
        check("reset_valid",  {31'b0, tvalid}, 32'h0);
        check("reset_data",   data,            32'h0);
        check("reset_strb",   {28'b0, tstrb},  32'h0);
        check("reset_beats",  beats,           32'h0);

        // 1: incrementing, contiguous, ready always high
        do_start(16'd4, 16'd2, 8'd0, 2'd0, 32'h10);
        check("t1_busy_after_start", {31'b0, busy}, 32'h1);
        run_stream(60, 1'b0);
        check("t1_done_seen", {31'b0, done_seen}, 32'h1);
        check("t1_nwords", got_words.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_word%0d", i), (i < got_words.size()) ? got_words[i] : 32'hx, 32'h10 + i);
            check($sformatf("t1_last%0d", i), (i < got_last.size()) ? {31'b0, got_last[i]} : 32'hx,
                  (i == 3 || i == 7) ? 32'h1 : 32'h0);
        end
        check("t1_contiguous", last_hs_cyc, 32'd7);
        check("t1_done_timing", done_cyc, 32'd8);
        check("t1_no_gap", gap_runs.size(), 32'd0);
        check("t1_strb", strb_err, 32'd0);
        check("t1_beats", beats, 32'd8);
        check("t1_busy_in_done", {31'b0, busy}, 32'h0);
        @(negedge clk);
        check("t1_done_one_cycle", {31'b0, done}, 32'h0);

        // 2: same config under backpressure
        do_start(16'd4, 16'd2, 8'd0, 2'd0, 32'h10);
        run_stream(100, 1'b1);
        check("t2_done_seen", {31'b0, done_seen}, 32'h1);
        check("t2_stall_stable", stall_err, 32'd0);
        check("t2_nwords", got_words.size(), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t2_word%0d", i), (i < got_words.size()) ? got_words[i] : 32'hx, 32'h10 + i);
        check("t2_last3", (got_last.size() > 3) ? {31'b0, got_last[3]} : 32'hx, 32'h1);
        check("t2_beats", beats, 32'd8);

        // 3: tagged pattern with inter-frame gaps
        do_start(16'd2, 16'd3, 8'd3, 2'd3, 32'hFFFF_FFFF);
        run_stream(60, 1'b0);
        exp_words = '{32'h0000_0000, 32'h0000_0001, 32'h0001_0000,
                      32'h0001_0001, 32'h0002_0000, 32'h0002_0001};
        check("t3_done_seen", {31'b0, done_seen}, 32'h1);
        check("t3_nwords", got_words.size(), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t3_word%0d", i), (i < got_words.size()) ? got_words[i] : 32'hx, exp_words[i]);
        check("t3_ngaps", gap_runs.size(), 32'd2);
        check("t3_gap0", (gap_runs.size() > 0) ? gap_runs[0] : -1, 32'd3);
        check("t3_gap1", (gap_runs.size() > 1) ? gap_runs[1] : -1, 32'd3);
        check("t3_beats", beats, 32'd6);

        // 4: empty runs (length 0, then count 0)
        do_start(16'd0, 16'd5, 8'd0, 2'd0, 32'h1);
        run_stream(10, 1'b0);
        check("t4a_done_seen", {31'b0, done_seen}, 32'h1);
        check("t4a_done_cyc", done_cyc, 32'd0);
        check("t4a_nwords", got_words.size(), 32'd0);
        check("t4a_busy", {31'b0, busy}, 32'h0);
        check("t4a_beats", beats, 32'd0);
        do_start(16'd5, 16'd0, 8'd0, 2'd0, 32'h1);
        run_stream(10, 1'b0);
        check("t4b_done_seen", {31'b0, done_seen}, 32'h1);
        check("t4b_nwords", got_words.size(), 32'd0);
        @(negedge clk);
        check("t4b_busy_after", {31'b0, busy}, 32'h0);
        check("t4b_done_after", {31'b0, done}, 32'h0);

        // 5: LFSR with zero seed; a second start while busy is ignored
        do_start(16'd16, 16'd1, 8'd0, 2'd2, 32'h0);
        start        = 1'b1;
        pattern_mode = 2'd0;
        pattern_seed = 32'h55;
        frame_length = 16'd3;
        @(negedge clk);
        start = 1'b0;
        check("t5_first_word_stalled", data, 32'h0000_0001);
        run_stream(60, 1'b0);
        check("t5_done_seen", {31'b0, done_seen}, 32'h1);
        check("t5_nwords", got_words.size(), 32'd16);
        check("t5_word1_hand", (got_words.size() > 1) ? got_words[1] : 32'hx, 32'h8020_0003);
        check("t5_word2_hand", (got_words.size() > 2) ? got_words[2] : 32'hx, 32'hC030_0002);
        s = 32'h1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t5_word%0d", i), (i < got_words.size()) ? got_words[i] : 32'hx, s);
            s = {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
        end
        check("t5_last15", (got_last.size() > 15) ? {31'b0, got_last[15]} : 32'hx, 32'h1);
        check("t5_beats", beats, 32'd16);

        // 6: reset on the 3rd beat of a length-8 frame, then a clean restart
        do_start(16'd8, 16'd1, 8'd0, 2'd0, 32'h100);
        tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_third_beat", data, 32'h102);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_valid", {31'b0, tvalid}, 32'h0);
        check("t6_rst_busy",  {31'b0, busy},   32'h0);
        check("t6_rst_data",  data,            32'h0);
        check("t6_rst_last",  {31'b0, tlast},  32'h0);
        check("t6_rst_beats", beats,           32'h0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (done !== 1'b0 || tvalid !== 1'b0) bad++;
            @(negedge clk);
        end
        check("t6_no_done_after_rst", bad, 32'd0);
        do_start(16'd2, 16'd1, 8'd0, 2'd0, 32'h100);
        run_stream(20, 1'b0);
        check("t6_restart_done", {31'b0, done_seen}, 32'h1);
        check("t6_restart_nwords", got_words.size(), 32'd2);
        check("t6_restart_w0", (got_words.size() > 0) ? got_words[0] : 32'hx, 32'h100);
        check("t6_restart_w1", (got_words.size() > 1) ? got_words[1] : 32'hx, 32'h101);
        check("t6_restart_beats", beats, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
